// File: rtl/fanout_bcast_driver.sv
// Broadcast driver for a high-fanout net. Each source word is buffered in a
// small FIFO and presented to every sink. A word retires only after every
// sink has accepted it, so one stalled load holds back the source without
// dropping or duplicating words.
module fanout_bcast_driver #(
    parameter int WIDTH     = 8,
    parameter int NUM_SINKS = 20,
    parameter int DEPTH     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [WIDTH-1:0]               s_data,
    output logic [NUM_SINKS-1:0]           m_valid,
    input  logic [NUM_SINKS-1:0]           m_ready,
    output logic [NUM_SINKS*WIDTH-1:0]     m_data,
    output logic                           busy,
    output logic [15:0]                    bcast_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [NUM_SINKS-1:0] done;
    logic [NUM_SINKS-1:0] fire;
    logic                 head_valid;
    logic                 push;
    logic                 retire;

    // Pointer advance with explicit wrap so non-trivial depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A head word is on the net exactly while the FSM is delivering.
    assign head_valid = (state == DELIVER);
    // Readiness depends only on registered occupancy, never on sink readiness.
    assign s_ready    = (count < CNT_W'(DEPTH));
    assign push       = s_valid & s_ready;
    assign m_valid    = {NUM_SINKS{head_valid}} & ~done;
    assign fire       = m_valid & m_ready;
    assign retire     = head_valid & (&(done | fire));
    assign m_data     = {NUM_SINKS{mem[rd_ptr]}};
    assign busy       = head_valid;

    // Buffer storage carries no reset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers, occupancy, delivery mask and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            done      <= '0;
            bcast_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (retire) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                done      <= '0;
                bcast_cnt <= bcast_cnt + 16'd1;
            end else begin
                done <= done | fire;
            end
            if (push && !retire) begin
                count <= count + CNT_W'(1);
            end else if (!push && retire) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: deliver whenever the buffer will hold at least one word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (push) begin
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                if (retire && (count == CNT_W'(1)) && !push) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
